// File: rtl/my_add8_pkg.sv
// Shared constants for the my_add8 adder: default width and the value the
// output registers take while reset is asserted.
package my_add8_pkg;

    localparam int ADD_WIDTH = 8;
    localparam int MAX_WIDTH = 64;

    // Sized for the widest legal adder plus its carry; the top slices what it needs.
    localparam logic [MAX_WIDTH:0] RESET_VALUE = '0;

endpackage

// File: rtl/my_add8_full_adder.sv
// One-bit full adder cell, the building block of the ripple-carry chain.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic half_sum;

    assign half_sum = a ^ b;
    assign sum      = half_sum ^ cin;
    assign cout     = (a & b) | (cin & half_sum);

endmodule

// File: rtl/my_add8.sv
// Registered unsigned adder: a WIDTH-bit ripple-carry chain whose sum and
// final carry are captured every clock, one cycle of latency.
module my_add8
    import my_add8_pkg::*;
#(
    parameter int             WIDTH     = ADD_WIDTH,
    parameter logic [WIDTH:0] RST_VALUE = RESET_VALUE[WIDTH:0]
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    output logic [WIDTH-1:0] out,
    output logic             cout
);

    if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_width_check
        $error("my_add8: WIDTH must be between 1 and %0d", MAX_WIDTH);
    end

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_d;
    logic             cout_d;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    assign carry[0] = 1'b0;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
        full_adder u_fa (
            .a    (op1[gi]),
            .b    (op2[gi]),
            .cin  (carry[gi]),
            .sum  (sum_d[gi]),
            .cout (carry[gi+1])
        );
    end

    assign cout_d = carry[WIDTH];

    // Reset is asynchronous so the outputs clear without waiting for a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {cout_q, sum_q} <= RST_VALUE;
        end else begin
            {cout_q, sum_q} <= {cout_d, sum_d};
        end
    end

    assign out  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_my_add8.sv
// Scoreboard bench for my_add8 at WIDTH = 8, 1 and 16: directed vectors on the
// 8-bit instance, then random streams on all three against op1+op2.
module tb_my_add8;

    typedef struct {
        logic [16:0] val;
        string       name;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [7:0]  op1_8,  op2_8,  out_8;
    logic        cout_8;
    logic [0:0]  op1_1,  op2_1,  out_1;
    logic        cout_1;
    logic [15:0] op1_16, op2_16, out_16;
    logic        cout_16;

    int vectors     = 0;
    int miscompares = 0;

    exp_t q8[$];
    exp_t q1[$];
    exp_t q16[$];

    my_add8 #(.WIDTH(8)) dut8 (
        .clk (clk), .rst (rst), .op1 (op1_8), .op2 (op2_8), .out (out_8), .cout (cout_8)
    );

    my_add8 #(.WIDTH(1)) dut1 (
        .clk (clk), .rst (rst), .op1 (op1_1), .op2 (op2_1), .out (out_1), .cout (cout_1)
    );

    my_add8 #(.WIDTH(16)) dut16 (
        .clk (clk), .rst (rst), .op1 (op1_16), .op2 (op2_16), .out (out_16), .cout (cout_16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end else begin
            $display("ok   %s: %h at %0t", name, act, $time);
        end
    endtask

    // Monitor: registered outputs are stable at the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (q8.size() > 0) begin
            e = q8.pop_front();
            check(e.name, {8'd0, cout_8, out_8}, e.val);
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            check(e.name, {15'd0, cout_1, out_1}, e.val);
        end
        if (q16.size() > 0) begin
            e = q16.pop_front();
            check(e.name, {cout_16, out_16}, e.val);
        end
    end

    // Present operands, then after the capturing edge queue the hand-computed result.
    task automatic apply8(input logic [7:0] a, input logic [7:0] b,
                          input logic [8:0] exp, input string name);
        exp_t e;
        op1_8 = a;
        op2_8 = b;
        @(posedge clk);
        #1;
        e.val  = {8'd0, exp};
        e.name = name;
        q8.push_back(e);
    endtask

    initial begin
        exp_t e;
        rst    = 1'b1;
        op1_8  = 8'h0F;
        op2_8  = 8'h0F;
        op1_1  = '0;
        op2_1  = '0;
        op1_16 = '0;
        op2_16 = '0;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("reset_hold", {8'd0, cout_8, out_8}, 17'h0);
        end

        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        e.val = 17'h01E; e.name = "no_carry"; q8.push_back(e);

        apply8(8'hF0, 8'h0F, 9'h0FF, "full_ones");
        apply8(8'hFF, 8'h01, 9'h100, "wrap_one");
        apply8(8'hFF, 8'hFF, 9'h1FE, "wrap_ff");

        // Operands change mid-cycle; outputs must keep the previous sum.
        #2;
        op1_8 = 8'h01;
        op2_8 = 8'h01;
        #2;
        check("hold_mid", {8'd0, cout_8, out_8}, 17'h1FE);
        @(posedge clk);
        #1;
        e.val = 17'h002; e.name = "latency"; q8.push_back(e);

        apply8(8'hFF, 8'hFF, 9'h1FE, "pre_reset");
        #5;
        rst = 1'b1;
        #1;
        check("async_reset", {8'd0, cout_8, out_8}, 17'h0);
        op1_8 = 8'h33;
        op2_8 = 8'h44;
        @(posedge clk);
        #1;
        check("reset_discard", {8'd0, cout_8, out_8}, 17'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 40; i++) begin
            logic [7:0]  a8,  b8;
            logic [0:0]  a1,  b1;
            logic [15:0] a16, b16;
            a8  = 8'($urandom_range(0, 255));
            b8  = 8'($urandom_range(0, 255));
            a1  = 1'($urandom_range(0, 1));
            b1  = 1'($urandom_range(0, 1));
            a16 = 16'($urandom_range(0, 65535));
            b16 = 16'($urandom_range(0, 65535));
            if (i == 0) begin
                a16 = 16'hFFFF;
                b16 = 16'h0001;
            end
            op1_8  = a8;  op2_8  = b8;
            op1_1  = a1;  op2_1  = b1;
            op1_16 = a16; op2_16 = b16;
            @(posedge clk);
            #1;
            e.val = {8'd0, {1'b0, a8} + {1'b0, b8}};    e.name = "rand_w8";  q8.push_back(e);
            e.val = {15'd0, {1'b0, a1} + {1'b0, b1}};   e.name = "rand_w1";  q1.push_back(e);
            e.val = {1'b0, a16} + {1'b0, b16};          e.name = "rand_w16"; q16.push_back(e);
        end

        repeat (2) @(posedge clk);
        #1;
        check("queues_drained", 17'(q8.size() + q1.size() + q16.size()), 17'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/my_add8.md
MY_ADD8 -- requirements
Module: my_add8

Interface
- REQ-001: Parameter WIDTH, default 8, operand and sum width in bits. Legal range is 1 to 64.
- REQ-002: clk, input, 1 bit, sole clock; all state updates on its rising edge.
- REQ-003: rst, input, 1 bit, reset; asynchronous and active-high.
- REQ-004: op1, input, WIDTH bits, unsigned first operand.
- REQ-005: op2, input, WIDTH bits, unsigned second operand.
- REQ-006: out, output, WIDTH bits, registered sum bits [WIDTH-1:0].
- REQ-007: cout, output, 1 bit, registered carry out of bit WIDTH-1.
- REQ-008: The block SHALL have no other ports: no carry-in, no valid/ready handshake.

Function
- REQ-009: The block SHALL compute {cout, out} = op1 + op2 as an unsigned (WIDTH+1)-bit sum.
  - The combinational sum SHALL be captured into the output registers on every rising clk edge while rst is low.
- REQ-010: Latency SHALL be exactly one clock.
  - Operands stable before rising edge N SHALL appear on out/cout after edge N.
  - The outputs SHALL hold until edge N+1.
- REQ-011: Throughput SHALL be one addition per clock, with no stall or bubble.
- REQ-012: Overflow SHALL wrap modulo 2^WIDTH in out, with the lost bit reported on cout.
  - Example: all-ones + 1 gives out = 0, cout = 1.
- REQ-013: cout SHALL be the true carry of the full-width addition, not a signed-overflow flag.
- REQ-014: Operand changes between clock edges SHALL have no effect on the outputs until the next rising edge.
  - The outputs SHALL be glitch-free.
- REQ-015: The adder SHALL be a ripple-carry chain of WIDTH one-bit full adders.
  - Bit 0 carry-in SHALL be constant 0.
  - Carry i+1 SHALL be the carry-out of bit i.
  - cout SHALL be the final carry.
- REQ-016: X/Z on any operand bit SHALL propagate only to the affected sum/carry bits.
  - The block SHALL not intentionally mask unknowns.

Reset
- REQ-017: While rst is high, out SHALL be 0 and cout SHALL be 0, independent of clk.
  - The outputs SHALL clear immediately on rst assertion, including mid-operation.
- REQ-018: On rst deassertion, the first capture SHALL occur at the next rising clk edge.
  - A result pending when rst asserted SHALL be discarded.
- REQ-019: Every flip-flop in the block SHALL be reset.

Structure
- REQ-020: Sub-module full_adder SHALL have ports a, b, cin, sum, cout.
  - sum = a^b^cin.
  - cout = (a&b)|(cin&(a^b)).
  - my_add8 SHALL instantiate WIDTH copies via a generate loop.
- REQ-021: A shared package SHALL hold:
  - the default width constant ADD_WIDTH = 8;
  - the reset output value constant (all zeros).
  - my_add8 SHALL use these as parameter defaults.
- REQ-022: Combinational adder logic and the output register stage SHALL be in separate always/assign regions of my_add8.

Verification
- REQ-023: Scenarios with WIDTH = 8:
  - Reset: rst=1 with op1=0x0F, op2=0x0F, clk toggling -> out=0x00, cout=0 throughout.
  - No carry: op1=0x0F, op2=0x0F, one edge after rst low -> out=0x1E, cout=0.
  - Full ones, no carry: op1=0xF0, op2=0x0F -> out=0xFF, cout=0 after one edge.
  - Wrap: op1=0xFF, op2=0x01 -> out=0x00, cout=1. Then op1=0xFF, op2=0xFF -> out=0xFE, cout=1 on the following edge.
  - Latency/hold: change operands mid-cycle to 0x01+0x01 -> outputs unchanged until the next rising edge, then out=0x02, cout=0.
  - Reset mid-run: assert rst asynchronously between edges while out=0xFE, cout=1 -> out=0x00, cout=0 immediately, before any clock edge.
- REQ-024: The bench SHALL also run random operand streams against a reference model op1+op2 with one-cycle delay.
  - It SHALL check every cycle.
  - It SHALL repeat the random run at WIDTH = 1 and WIDTH = 16.
